// File: rtl/uart_transmitter_pkg.sv
// Shared constants, state encoding and helpers for the UART transmitter.
// Imported by the FIFO, the interface users and the top.
package uart_transmitter_pkg;

    localparam int FIFO_DEPTH = 16;
    localparam int PTR_W      = $clog2(FIFO_DEPTH) + 1;

    localparam logic [3:0] FRAME_LEN_NP = 4'd10;
    localparam logic [3:0] FRAME_LEN_P  = 4'd11;

    typedef enum logic {
        IDLE_TX    = 1'b0,
        SHIFT_DATA = 1'b1
    } tx_state_e;

    // Even parity is the XOR of the data; odd is its complement.
    function automatic logic parity_bit(
        input logic [7:0] data,
        input logic       even
    );
        return even ? ^data : ~^data;
    endfunction

    // TX-empty threshold compare.
    function automatic logic txe_hit(
        input logic [PTR_W-1:0] count,
        input logic [1:0]       txt
    );
        logic hit;
        hit = 1'b0;
        unique case (txt)
            2'b00: hit = (count == PTR_W'(0));
            2'b01: hit = (count <= PTR_W'(8));
            2'b10: hit = (count <= PTR_W'(4));
            2'b11: hit = (count <= PTR_W'(2));
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Control inputs and status outputs of the UART transmitter.
// The register block is the master, the transmitter the slave.
interface uart_transmitter_if;

    logic       ctrl_en;
    logic       ctrl_d9;
    logic       ctrl_ep;
    logic       ctrl_shift_tx;
    logic       ctrl_data_wr;
    logic [7:0] ctrl_data_in;
    logic [1:0] ctrl_txt;

    logic       uart_tx;
    logic       tx_nf;
    logic       tx_busy;
    logic       tx_txe;
    logic       tx_ov;

    modport master (
        output ctrl_en, ctrl_d9, ctrl_ep, ctrl_shift_tx,
        output ctrl_data_wr, ctrl_data_in, ctrl_txt,
        input  uart_tx, tx_nf, tx_busy, tx_txe, tx_ov
    );

    modport slave (
        input  ctrl_en, ctrl_d9, ctrl_ep, ctrl_shift_tx,
        input  ctrl_data_wr, ctrl_data_in, ctrl_txt,
        output uart_tx, tx_nf, tx_busy, tx_txe, tx_ov
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// 16x8 TX FIFO with wrap-bit pointers and a flush that drops all entries.
// Read data is combinational at the read pointer.
module uart_tx_fifo
    import uart_transmitter_pkg::*;
(
    input  logic             pclk,
    input  logic             preset_n,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             rd_en,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [PTR_W-1:0] count,
    output logic [7:0]       data_out
);

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;

    // Next pointers; a flush moves the read pointer onto the write pointer.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            rptr_d = wptr_q;
        end else begin
            if (wr_en) wptr_d = wptr_q + PTR_W'(1);
            if (rd_en) rptr_d = rptr_q + PTR_W'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge pclk) begin
        if (wr_en && !flush) mem_q[wptr_q[PTR_W-2:0]] <= wr_data;
    end

    assign full  = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
                   (wptr_q[PTR_W-2:0] == rptr_q[PTR_W-2:0]);
    assign empty    = (wptr_q == rptr_q);
    assign count    = wptr_q - rptr_q;
    assign data_out = mem_q[rptr_q[PTR_W-2:0]];

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: FIFO-fed frame serialiser driven by a 16x baud tick.
// Frame is start, 8 data LSB first, optional parity, stop.
module uart_transmitter
    import uart_transmitter_pkg::*;
(
    input  logic          pclk,
    input  logic          preset_n,
    uart_transmitter_if.slave bus
);

    tx_state_e        state_q, state_d;
    logic [3:0]       smp_cnt_q, smp_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [10:0]      shreg_q, shreg_d;
    logic             d9_q, d9_d;
    logic             uart_tx_q, uart_tx_d;
    logic             ov_q, ov_d;

    logic             full;
    logic             empty;
    logic [PTR_W-1:0] count;
    logic [7:0]       fifo_dout;
    logic             wr_acc;
    logic             pop;
    logic             slot9;
    logic [3:0]       frame_len;

    assign wr_acc = bus.ctrl_data_wr && !full && bus.ctrl_en;
    assign pop    = (state_q == IDLE_TX) && bus.ctrl_en && !empty;

    // Without parity the parity slot carries the stop bit.
    assign slot9 = bus.ctrl_d9 ?
                   parity_bit(fifo_dout, bus.ctrl_ep) : 1'b1;

    // Frame length follows the parity mode latched at load.
    assign frame_len = d9_q ? FRAME_LEN_P : FRAME_LEN_NP;

    uart_tx_fifo u_fifo (
        .pclk     (pclk),
        .preset_n (preset_n),
        .wr_en    (wr_acc),
        .wr_data  (bus.ctrl_data_in),
        .rd_en    (pop),
        .flush    (!bus.ctrl_en),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .data_out (fifo_dout)
    );

    // Frame FSM, sample/bit counters and shift register next state.
    always_comb begin
        state_d   = state_q;
        smp_cnt_d = smp_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        d9_d      = d9_q;
        uart_tx_d = 1'b1;
        if (!bus.ctrl_en) begin
            state_d   = IDLE_TX;
            smp_cnt_d = '0;
            bit_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE_TX: begin
                    if (pop) begin
                        state_d   = SHIFT_DATA;
                        shreg_d   = {1'b1, slot9, fifo_dout, 1'b0};
                        d9_d      = bus.ctrl_d9;
                        smp_cnt_d = '0;
                        bit_cnt_d = '0;
                    end
                end
                SHIFT_DATA: begin
                    uart_tx_d = shreg_q[0];
                    if (bus.ctrl_shift_tx) begin
                        smp_cnt_d = smp_cnt_q + 4'd1;
                        if (smp_cnt_q == 4'hF) begin
                            shreg_d   = {1'b1, shreg_q[10:1]};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            if (bit_cnt_d == frame_len) begin
                                state_d = IDLE_TX;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Overrun is sticky until the next accepted write or a disable.
    always_comb begin
        ov_d = ov_q;
        if (!bus.ctrl_en) begin
            ov_d = 1'b0;
        end else if (bus.ctrl_data_wr && full) begin
            ov_d = 1'b1;
        end else if (wr_acc) begin
            ov_d = 1'b0;
        end
    end

    // State, datapath and flag registers.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q   <= IDLE_TX;
            smp_cnt_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '1;
            d9_q      <= 1'b0;
            uart_tx_q <= 1'b1;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            smp_cnt_q <= smp_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            d9_q      <= d9_d;
            uart_tx_q <= uart_tx_d;
            ov_q      <= ov_d;
        end
    end

    assign bus.uart_tx = uart_tx_q;
    assign bus.tx_nf   = !full;
    assign bus.tx_busy = (state_q == SHIFT_DATA);
    assign bus.tx_txe  = txe_hit(count, bus.ctrl_txt);
    assign bus.tx_ov   = ov_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: queued expected frames are
// compared by a line monitor; flags are checked inline.
module tb_uart_transmitter;

    typedef struct {
        logic [10:0] bits;
        int          nbits;
    } frame_t;

    typedef struct {
        logic [7:0]  data;
        logic        d9;
        logic        ep;
        logic [10:0] bits;
        int          nbits;
    } vec_t;

    logic pclk;
    logic preset_n;
    int   checks;
    int   errors;
    bit   tick_en;
    bit   mon_en;
    bit   mon_busy;
    frame_t exp_q[$];
    vec_t   vecs[3];

    uart_transmitter_if u_if();

    uart_transmitter dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .bus      (u_if.slave)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [10:0] bits, input int n);
        frame_t f;
        f.bits  = bits;
        f.nbits = n;
        exp_q.push_back(f);
    endtask

    task automatic wr_byte(input logic [7:0] b);
        @(negedge pclk);
        u_if.ctrl_data_wr = 1'b1;
        u_if.ctrl_data_in = b;
        @(negedge pclk);
        u_if.ctrl_data_wr = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy || u_if.tx_busy) &&
               n < budget) begin
            @(negedge pclk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     exp_q.size());
        end
    endtask

    task automatic wait_busy(input logic lvl, input int budget,
                             input string name);
        int n;
        n = 0;
        while (u_if.tx_busy !== lvl && n < budget) begin
            @(negedge pclk);
            n++;
        end
        check(name, u_if.tx_busy, lvl);
    endtask

    // 16x tick, one pclk wide, every 4 pclk.
    initial begin
        int ph;
        ph = 0;
        u_if.ctrl_shift_tx = 1'b0;
        forever begin
            @(negedge pclk);
            ph = (ph + 1) % 4;
            u_if.ctrl_shift_tx = tick_en && (ph == 0);
        end
    end

    // Line monitor: find a start bit, sample mid-bit every 64 pclk.
    initial begin
        logic        prev;
        logic [10:0] got;
        bit          lost;
        frame_t      f;
        prev     = 1'b1;
        mon_busy = 1'b0;
        forever begin
            @(negedge pclk);
            if (mon_en && prev && !u_if.uart_tx) begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got start expected idle");
                end else begin
                    f    = exp_q.pop_front();
                    got  = '0;
                    lost = 1'b0;
                    repeat (31) @(negedge pclk);
                    for (int b = 0; b < f.nbits; b++) begin
                        got[b] = u_if.uart_tx;
                        if (!mon_en) lost = 1'b1;
                        if (b != f.nbits - 1) repeat (64) @(negedge pclk);
                    end
                    if (!lost) check("frame", got, f.bits);
                end
                mon_busy = 1'b0;
            end
            prev = u_if.uart_tx;
        end
    end

    initial begin
        int n;
        checks = 0;
        errors = 0;
        tick_en = 1'b0;
        mon_en  = 1'b0;
        u_if.ctrl_en      = 1'b1;
        u_if.ctrl_d9      = 1'b0;
        u_if.ctrl_ep      = 1'b0;
        u_if.ctrl_data_wr = 1'b0;
        u_if.ctrl_data_in = 8'h00;
        u_if.ctrl_txt     = 2'b00;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 11'h34A, 10};
        vecs[1] = '{8'h03, 1'b1, 1'b1, 11'h406, 11};
        vecs[2] = '{8'h03, 1'b1, 1'b0, 11'h606, 11};

        preset_n = 1'b0;
        repeat (3) @(negedge pclk);
        check("rst_uart_tx", u_if.uart_tx, 1);
        check("rst_nf", u_if.tx_nf, 1);
        check("rst_busy", u_if.tx_busy, 0);
        check("rst_txe", u_if.tx_txe, 1);
        check("rst_ov", u_if.tx_ov, 0);
        preset_n = 1'b1;
        repeat (2) @(negedge pclk);

        // Single frames, with and without parity.
        tick_en = 1'b1;
        mon_en  = 1'b1;
        foreach (vecs[i]) begin
            u_if.ctrl_d9 = vecs[i].d9;
            u_if.ctrl_ep = vecs[i].ep;
            push_exp(vecs[i].bits, vecs[i].nbits);
            wr_byte(vecs[i].data);
            drain(2000);
            check("idle_line", u_if.uart_tx, 1);
            check("idle_txe", u_if.tx_txe, 1);
        end

        // Parity mode changed mid-frame applies to the next load only.
        u_if.ctrl_d9 = 1'b1;
        u_if.ctrl_ep = 1'b1;
        push_exp(11'h502, 11);
        wr_byte(8'h81);
        repeat (2) @(negedge pclk);
        u_if.ctrl_d9 = 1'b0;
        u_if.ctrl_ep = 1'b0;
        drain(2000);

        // Back-to-back frames with a short idle gap.
        push_exp(11'h278, 10);
        push_exp(11'h2B4, 10);
        wr_byte(8'h3C);
        wr_byte(8'h5A);
        wait_busy(1'b1, 20, "b2b_busy_rise");
        wait_busy(1'b0, 1000, "b2b_busy_fall");
        n = 0;
        while (!u_if.tx_busy && n < 10) begin
            @(negedge pclk);
            n++;
        end
        check("b2b_gap_le2", (n <= 2), 1);
        drain(2000);

        // Fill the FIFO without ticks: one byte sits in the shifter.
        mon_en  = 1'b0;
        tick_en = 1'b0;
        repeat (2) @(negedge pclk);
        for (int i = 0; i < 17; i++) wr_byte(8'h10 + 8'(i));
        check("full_nf", u_if.tx_nf, 0);
        check("full_ov_clear", u_if.tx_ov, 0);
        check("full_busy", u_if.tx_busy, 1);
        wr_byte(8'hEE);
        check("ov_set", u_if.tx_ov, 1);
        check("ov_nf", u_if.tx_nf, 0);
        tick_en = 1'b1;
        n = 0;
        while (!u_if.tx_nf && n < 2000) begin
            @(negedge pclk);
            n++;
        end
        check("nf_after_pop", u_if.tx_nf, 1);
        check("ov_held", u_if.tx_ov, 1);
        wr_byte(8'h77);
        check("ov_cleared_by_wr", u_if.tx_ov, 0);
        check("refull_nf", u_if.tx_nf, 0);
        wr_byte(8'h99);
        check("ov_set2", u_if.tx_ov, 1);
        u_if.ctrl_en = 1'b0;
        @(negedge pclk);
        check("dis_ov", u_if.tx_ov, 0);
        check("dis_busy", u_if.tx_busy, 0);
        check("dis_line", u_if.uart_tx, 1);
        check("dis_txe", u_if.tx_txe, 1);
        check("dis_nf", u_if.tx_nf, 1);
        wr_byte(8'h55);
        check("dis_wr_ignored", u_if.tx_txe, 1);
        u_if.ctrl_en = 1'b1;
        repeat (2) @(negedge pclk);
        check("reen_idle", u_if.tx_busy, 0);

        // Threshold 10 then abort mid data bit 3.
        tick_en = 1'b0;
        u_if.ctrl_txt = 2'b10;
        for (int i = 0; i < 6; i++) wr_byte(8'h20 + 8'(i));
        check("txe_cnt5", u_if.tx_txe, 0);
        tick_en = 1'b1;
        wait_busy(1'b0, 2000, "thr_frame_end");
        check("txe_idle_cnt5", u_if.tx_txe, 0);
        @(negedge pclk);
        check("txe_cnt4", u_if.tx_txe, 1);
        check("second_busy", u_if.tx_busy, 1);
        repeat (290) @(negedge pclk);
        check("mid_bit3", u_if.uart_tx, 0);
        u_if.ctrl_en = 1'b0;
        @(negedge pclk);
        check("abort_line", u_if.uart_tx, 1);
        check("abort_busy", u_if.tx_busy, 0);
        check("abort_txe", u_if.tx_txe, 1);
        u_if.ctrl_txt = 2'b00;
        check("abort_empty", u_if.tx_txe, 1);
        u_if.ctrl_en = 1'b1;
        repeat (2) @(negedge pclk);

        // Asynchronous reset mid-frame.
        wr_byte(8'h6B);
        repeat (200) @(negedge pclk);
        check("pre_rst_busy", u_if.tx_busy, 1);
        @(posedge pclk);
        #2;
        preset_n = 1'b0;
        #1;
        check("arst_line", u_if.uart_tx, 1);
        check("arst_busy", u_if.tx_busy, 0);
        check("arst_nf", u_if.tx_nf, 1);
        check("arst_txe", u_if.tx_txe, 1);
        check("arst_ov", u_if.tx_ov, 0);
        @(negedge pclk);
        preset_n = 1'b1;
        repeat (3) @(negedge pclk);
        check("post_rst_line", u_if.uart_tx, 1);
        check("post_rst_busy", u_if.tx_busy, 0);
        mon_en = 1'b1;
        push_exp(11'h2B4, 10);
        wr_byte(8'h5A);
        drain(2000);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
